cln_phychan_vc_sched: RTL

CLN_PHYCHAN_VC_SCHED -- requirements
Module: cln_phychan_vc_sched

---
 rtl/cln_phychan_vc_sched_if.sv | 28 ++
 rtl/cln_phychan_vc_sched.sv | 123 ++++++++++++
 2 files changed

// File: rtl/cln_phychan_vc_sched_if.sv
// Virtual-channel request side and physical-channel cell side of the VC scheduler.
interface cln_phychan_vc_sched_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NCHAN      = 4,
   parameter int CRDSZ      = 4
);
   localparam int VCHAN_ID_SZ = (NCHAN < 2) ? 1 : $clog2(NCHAN);

   logic [NCHAN-1:0]            req_valid;
   logic [NCHAN*DATA_WIDTH-1:0] req_payload;
   logic [NCHAN-1:0]            req_accept;
   logic [DATA_WIDTH-1:0]       payload;
   logic [VCHAN_ID_SZ-1:0]      chan_id;
   logic                        valid;
   logic                        accept;
   logic [NCHAN*CRDSZ-1:0]      credit;
   logic                        credit_err;

   modport slave (
      input  req_valid, req_payload, accept, credit,
      output req_accept, payload, chan_id, valid, credit_err
   );

   modport master (
      output req_valid, req_payload, accept, credit,
      input  req_accept, payload, chan_id, valid, credit_err
   );
endinterface

// File: rtl/cln_phychan_vc_sched.sv
// Credit-based round-robin scheduler muxing NCHAN virtual channels onto one
// physical channel through a single output register.
module cln_phychan_vc_lane #(
   parameter int CRDSZ    = 4,
   parameter int VC_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic             gnt,
   input  logic [CRDSZ-1:0] credit,
   output logic             elig,
   output logic             over
);
   localparam logic [CRDSZ-1:0] DEPTH = CRDSZ'(VC_DEPTH);

   logic [CRDSZ-1:0] sent_cnt;
   logic [CRDSZ-1:0] outstanding;

   // Both counters wrap; the modular difference is the receiver occupancy.
   assign outstanding = sent_cnt - credit;
   assign elig        = req && (outstanding < DEPTH);
   assign over        = outstanding > DEPTH;

   always_ff @(posedge clk) begin
      if (rst)      sent_cnt <= '0;
      else if (gnt) sent_cnt <= sent_cnt + 1'b1;
   end
endmodule

module cln_phychan_vc_sched #(
   parameter int DATA_WIDTH = 32,
   parameter int NCHAN      = 4,
   parameter int CRDSZ      = 4,
   parameter int VC_DEPTH   = 8
) (
   input logic                   clk,
   input logic                   rst,
   cln_phychan_vc_sched_if.slave bus
);
   localparam int VCHAN_ID_SZ = (NCHAN < 2) ? 1 : $clog2(NCHAN);

   logic [NCHAN-1:0]       elig;
   logic [NCHAN-1:0]       over;
   logic [NCHAN-1:0]       gnt_vec;
   logic                   gnt_any;
   logic [VCHAN_ID_SZ-1:0] gnt_idx;
   logic [VCHAN_ID_SZ-1:0] rr_ptr;
   logic                   load;
   logic                   grant;
   logic                   valid_q;
   logic                   err_q;
   logic [DATA_WIDTH-1:0]  payload_q;
   logic [VCHAN_ID_SZ-1:0] chan_id_q;

   for (genvar i = 0; i < NCHAN; i++) begin : g_lane
      cln_phychan_vc_lane #(.CRDSZ(CRDSZ), .VC_DEPTH(VC_DEPTH)) u_lane (
         .clk    (clk),
         .rst    (rst),
         .req    (bus.req_valid[i]),
         .gnt    (gnt_vec[i]),
         .credit (bus.credit[i*CRDSZ +: CRDSZ]),
         .elig   (elig[i]),
         .over   (over[i])
      );
      assign gnt_vec[i] = grant && (gnt_idx == VCHAN_ID_SZ'(i));
   end

   // First eligible channel at or after rr_ptr, wrapping at NCHAN.
   always_comb begin : arb
      int                     idx;
      logic [VCHAN_ID_SZ-1:0] cand;
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      cand    = '0;
      for (int k = 0; k < NCHAN; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NCHAN) idx = idx - NCHAN;
         cand = VCHAN_ID_SZ'(idx);
         if (!gnt_any && elig[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   assign load  = !valid_q || bus.accept;
   assign grant = load && gnt_any && !rst;

   if (NCHAN > 1) begin : g_rr
      always_ff @(posedge clk) begin
         if (rst)        rr_ptr <= '0;
         else if (grant) rr_ptr <= (gnt_idx == VCHAN_ID_SZ'(NCHAN-1)) ? '0 : gnt_idx + 1'b1;
      end
   end else begin : g_no_rr
      assign rr_ptr = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
         chan_id_q <= '0;
         err_q     <= 1'b0;
      end else begin
         if (load) begin
            valid_q <= gnt_any;
            if (gnt_any) begin
               payload_q <= bus.req_payload[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
               chan_id_q <= gnt_idx;
            end
         end
         if (|over) err_q <= 1'b1;
      end
   end

   assign bus.req_accept = gnt_vec;
   assign bus.payload    = payload_q;
   assign bus.chan_id    = chan_id_q;
   assign bus.valid      = valid_q;
   assign bus.credit_err = err_q;
endmodule
